// File: rtl/uart_rcv.sv
// 16x-oversampling UART receiver: 8N1 frames, or 8E1 when UART_RCV_PARITY_EN is defined.
// Glitched start bits are dropped; a low stop bit pulses ferr and discards the frame.
module uart_rcv #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr,
    output logic       perr
);

    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RCV_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic             rxs_p0, rxs, rxs_d;
    logic             fall;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       tcnt;
    logic [2:0]       bcnt;
    logic [7:0]       shreg;
    logic             cnt_clr, mid_start, bit_end, shift_en, stop_smp;
`ifdef UART_RCV_PARITY_EN
    logic             par_bit;
    logic             par_en;
`endif

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    // Stage: two-flop synchroniser plus one flop for falling-edge detection
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            rxs_p0 <= 1'b1;
            rxs    <= 1'b1;
            rxs_d  <= 1'b1;
        end else begin
            rxs_p0 <= rxd;
            rxs    <= rxs_p0;
            rxs_d  <= rxs;
        end
    end

    assign fall = rxs_d & ~rxs;
    assign tick = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));

    // State register
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (tick && tcnt == 4'd7) state_nxt = rxs ? IDLE : DATA;
            DATA: begin
                if (tick && tcnt == 4'd15 && bcnt == 3'd7) begin
`ifdef UART_RCV_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RCV_PARITY_EN
            PARITY: if (tick && tcnt == 4'd15) state_nxt = STOP;
`endif
            STOP:  if (tick && tcnt == 4'd15) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode
    always_comb begin
        cnt_clr   = (state == IDLE) && fall;
        mid_start = (state == START) && tick && (tcnt == 4'd7);
        bit_end   = tick && (tcnt == 4'd15);
        shift_en  = (state == DATA) && bit_end;
        stop_smp  = (state == STOP) && bit_end;
`ifdef UART_RCV_PARITY_EN
        par_en    = (state == PARITY) && bit_end;
`endif
    end

    // Stage: oversampling counters and shift register
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tcnt    <= 4'd0;
            bcnt    <= 3'd0;
            shreg   <= 8'h00;
`ifdef UART_RCV_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state == IDLE || div_cnt == DIV_W'(DIV - 1))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            // tcnt restarts at the start edge and again at mid start bit,
            // so every later bit is sampled one full bit period apart.
            if (cnt_clr || (mid_start && !rxs))
                tcnt <= 4'd0;
            else if (tick)
                tcnt <= tcnt + 4'd1;

            if (cnt_clr)
                bcnt <= 3'd0;
            else if (shift_en)
                bcnt <= bcnt + 3'd1;

            if (shift_en)
                shreg <= {rxs, shreg[7:1]};
`ifdef UART_RCV_PARITY_EN
            if (par_en)
                par_bit <= rxs;
`endif
        end
    end

    // Stage: registered result and one-cycle status pulses
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            data  <= 8'h00;
            valid <= 1'b0;
            ferr  <= 1'b0;
`ifdef UART_RCV_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            valid <= stop_smp && rxs;
            ferr  <= stop_smp && !rxs;
            if (stop_smp && rxs)
                data <= shreg;
`ifdef UART_RCV_PARITY_EN
            perr  <= stop_smp && rxs && (even_par(shreg) != par_bit);
`endif
        end
    end

`ifndef UART_RCV_PARITY_EN
    assign perr = 1'b0;
`endif

endmodule

// File: doc/uart_rcv.md
# uart_rcv

Serial data receiver: the receive-side counterpart of `uart_xmit`, consuming its `txd` line (or an external RS-232 RX pin) and producing parallel bytes. It synchronises the asynchronous `rxd` input, oversamples at 16× the baud rate, and samples each bit at its midpoint. It rejects glitched start bits and flags framing errors. Each received byte is presented on `data` with a one-cycle `valid` strobe for the downstream consumer.

## Interface
- `CLK_FREQ`, 100_000_000: input clock frequency in Hz.
- `BAUD`, 9600: line rate in bits/s. The 16× tick divisor is `DIV = CLK_FREQ/(BAUD*16)`, truncated, and must be ≥ 1.

- `clk100MHz`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `rxd`  in  1  serial input, idle high, asynchronous to `clk100MHz`.
- `data`  out  8  last correctly framed byte, held until the next one.
- `valid`  out  1  one-cycle pulse: `data` has just been updated.
- `ferr`  out  1  one-cycle pulse: stop bit sampled low; frame discarded.
- `perr`  out  1  one-cycle pulse: parity mismatch (see Configuration).

## Operation
- Synchroniser: `rxd` passes through two flops to give `rxs`. A third flop `rxs_d` feeds a falling-edge detector (`rxs_d=1 & rxs=0`).
- Tick generator: counter from 0 to `DIV-1`, emitting a one-cycle `tick` at wrap. It runs freely outside IDLE and is cleared on entry to START.
- `tcnt` (4 bits) counts ticks within a bit. `bcnt` (3 bits) counts data bits.
- States:
  - IDLE: a falling edge moves to START; `tcnt` and the divider are cleared.
  - START: at `tcnt=7` (mid start bit), sample `rxs`. If 1, it is a glitch; return to IDLE with no output. If 0, clear `tcnt` and go to DATA.
  - DATA: at each `tcnt=15`, shift `rxs` into a shift register, LSB first. After the 8th bit (`bcnt` wraps 7→0), go to STOP (or PARITY when enabled).
  - PARITY (enabled builds only): at `tcnt=15`, sample the parity bit and go to STOP.
  - STOP: at `tcnt=15`, sample `rxs`.
    - If 1: load `data`, pulse `valid` (and `perr` on mismatch). Go to IDLE.
    - If 0: pulse `ferr`, leave `data` unchanged, go to IDLE.
- Recovery from a line held low after a framing error: no new start is detected until `rxs` has returned high and then falls again.
- Reset: all of the following are cleared immediately and asynchronously: state = IDLE, `data=8'h00`, `valid=0`, `ferr=0`, `perr=0`, counters 0, synchroniser flops 1 (idle). A reset mid-frame abandons the frame with no output.

## Timing
- Input latency: 2 cycles through the synchroniser, plus 1 cycle for edge detection.
- `valid`, `ferr` and `perr` are registered and assert in the cycle after the stop-bit sample tick. They stay high for exactly 1 cycle.
- Frame length: 10 bit periods (11 with parity), i.e. 160 (176) ticks from the start edge nominally.
- The stop decision occurs at 9.5 bit periods, so a new start edge arriving half a bit after the stop midpoint is accepted. Back-to-back frames are received without loss.
- `data` is stable between `valid` pulses. There is no back-pressure: a consumer that misses `valid` loses the byte.
- Tolerated baud mismatch: ±3 % cumulative error over the frame.

## Configuration
- Macro `UART_RCV_PARITY_EN`.
  - Defined: the frame carries one even-parity bit after D7, and the PARITY state is present. On mismatch, `data` is still loaded and `valid` pulses, with `perr` asserted in the same cycle.
  - Undefined: 8N1 frames, no PARITY state, and `perr` is tied to 0.

## Test plan
- Bench parameters: `CLK_FREQ=100_000_000`, `BAUD=6_250_000`, giving `DIV=1` and a 16-cycle bit.
- Reset: hold `rst=0` for 3 cycles with `rxd=1` → `data=8'h00`, `valid=ferr=perr=0`; release → outputs unchanged and no pulses while the line is idle.
- Single byte: drive the 8N1 frame for 8'h55 → exactly one `valid` pulse, `data=8'h55`, 1 cycle after the stop-bit midpoint.
- Back-to-back: 8'h33, 8'h0F, 8'h00 with no idle gap → three `valid` pulses in order with matching `data` and no `ferr`.
- Glitch and framing:
  - `rxd` low for 4 cycles, then high → no state change past START and no pulses.
  - Frame 8'hA5 with the stop bit driven 0 → `ferr` pulse, `data` keeps its previous value, no `valid`.
- Reset mid-frame: assert `rst` during D3 of 8'hFF → outputs clear at once. A following 8'h12 frame is received correctly.
- Parity (`UART_RCV_PARITY_EN`):
  - 8'h07 with parity bit 1 → `valid` with `perr=0`.
  - 8'h07 with parity bit 0 → `valid` and `perr` in the same cycle.
